// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - ID-stage register hazard scoreboard for long-latency producers
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   id_valid                       valid instruction in ID
//   id_rs1/id_rs2, id_rs*_used     ID source registers and whether they are read
//   id_rd, id_reg_write, id_long   ID destination, writes rd, long-latency producer
//   id_branch                      ID resolves branch/jalr and needs final operands
//   ex_valid, ex_reg_write, ex_rd  short-latency producer currently in EX
//   wb_valid, wb_rd                long-latency result completing this cycle
//   flush                          squash the ID instruction
//   stall, stall_cause             hold ID (cause 1=RAW 2=BR 3=WAW 4=FULL, 0=none)
//   busy_vec                       one bit per register with a pending long write
//   pend_cnt                       outstanding long-latency writes
//   err                            sticky: writeback to a register that was not busy
//   stall_cycles                   saturating count of stalled cycles

module hazard_scoreboard #(
   parameter int REG_AW   = 5,
   parameter int MAX_PEND = 4,
   parameter int PERF_W   = 32,
   localparam int NREG    = 2 ** REG_AW,
   localparam int CNT_W   = $clog2(MAX_PEND + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_rs1_used,
   input  logic              id_rs2_used,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_reg_write,
   input  logic              id_long,
   input  logic              id_branch,
   input  logic              ex_valid,
   input  logic              ex_reg_write,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              wb_valid,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic              flush,
   output logic              stall,
   output logic [2:0]        stall_cause,
   output logic [NREG-1:0]   busy_vec,
   output logic [CNT_W-1:0]  pend_cnt,
   output logic              err,
   output logic [PERF_W-1:0] stall_cycles
);

   localparam logic [CNT_W-1:0] MAX_PEND_C = CNT_W'(MAX_PEND);

   logic match1, match2;
   logic wb_hit1, wb_hit2, wb_hit_rd;
   logic raw, br, waw, full;
   logic long_wr;
   logic issue, clear, bad_wb;
   logic [NREG-1:0] busy_nxt;

   // Register 0 is hardwired, so it never creates a dependency.
   assign match1 = id_valid & id_rs1_used & (id_rs1 != '0);
   assign match2 = id_valid & id_rs2_used & (id_rs2 != '0);

   // A completing writeback is forwarded in the same cycle and resolves the hazard.
   assign wb_hit1   = wb_valid & (wb_rd == id_rs1);
   assign wb_hit2   = wb_valid & (wb_rd == id_rs2);
   assign wb_hit_rd = wb_valid & (wb_rd == id_rd);

   assign raw = (match1 & busy_vec[id_rs1] & ~wb_hit1) |
                (match2 & busy_vec[id_rs2] & ~wb_hit2);

   // Branches resolve in ID, so an EX producer cannot be forwarded in time.
   assign br = id_branch & ex_valid & ex_reg_write & (ex_rd != '0) &
               ((match1 & (ex_rd == id_rs1)) | (match2 & (ex_rd == id_rs2)));

   assign long_wr = id_valid & id_reg_write & id_long & (id_rd != '0);
   assign waw     = long_wr & busy_vec[id_rd] & ~wb_hit_rd;
   // A same-cycle completion does not free a slot for this cycle's issue.
   assign full    = long_wr & (pend_cnt == MAX_PEND_C);

   assign stall = (raw | br | waw | full) & ~flush;

   always_comb begin
      stall_cause = 3'd0;
      if (stall) begin
         if (raw)       stall_cause = 3'd1;
         else if (br)   stall_cause = 3'd2;
         else if (waw)  stall_cause = 3'd3;
         else           stall_cause = 3'd4;
      end
   end

   assign issue  = long_wr & ~stall & ~flush;
   assign clear  = wb_valid & (wb_rd != '0) & busy_vec[wb_rd];
   assign bad_wb = wb_valid & (wb_rd != '0) & ~busy_vec[wb_rd];

   // Set is applied after clear so a same-register set/clear leaves the bit busy.
   always_comb begin
      busy_nxt = busy_vec;
      if (clear) busy_nxt[wb_rd] = 1'b0;
      if (issue) busy_nxt[id_rd] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_vec     <= '0;
         pend_cnt     <= '0;
         err          <= 1'b0;
         stall_cycles <= '0;
      end else begin
         busy_vec <= busy_nxt;
         if (issue && !clear && pend_cnt != MAX_PEND_C)
            pend_cnt <= pend_cnt + 1'b1;
         else if (clear && !issue && pend_cnt != '0)
            pend_cnt <= pend_cnt - 1'b1;
         if (bad_wb)
            err <= 1'b1;
         if (stall && stall_cycles != '1)
            stall_cycles <= stall_cycles + 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed table-driven bench for hazard_scoreboard

module tb_hazard_scoreboard;

   typedef struct {
      logic       vld;
      logic [4:0] rs1;
      logic       u1;
      logic [4:0] rs2;
      logic       u2;
      logic [4:0] rd;
      logic       rw;
      logic       lng;
      logic       br;
      logic       exv;
      logic       exw;
      logic [4:0] exrd;
      logic       wbv;
      logic [4:0] wbrd;
      logic       fl;
      logic       est;
      logic [2:0] ecause;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic        id_valid, id_rs1_used, id_rs2_used, id_reg_write, id_long, id_branch;
   logic [4:0]  id_rs1, id_rs2, id_rd, ex_rd, wb_rd;
   logic        ex_valid, ex_reg_write, wb_valid, flush;
   logic        stall;
   logic [2:0]  stall_cause;
   logic [31:0] busy_vec;
   logic [2:0]  pend_cnt;
   logic        err;
   logic [31:0] stall_cycles;

   logic        s_vld, s_u1, s_rw, s_lng;
   logic [4:0]  s_rs1, s_rd;
   logic        s_stall;
   logic [2:0]  s_cause;
   logic [31:0] s_busy;
   logic [2:0]  s_pend;
   logic        s_err;
   logic [3:0]  s_cycles;

   int checks = 0;
   int errors = 0;
   vec_t tbl[17];

   hazard_scoreboard dut (
      .clk(clk), .rst_n(rst_n),
      .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .id_rd(id_rd), .id_reg_write(id_reg_write), .id_long(id_long),
      .id_branch(id_branch), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
      .ex_rd(ex_rd), .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
      .stall(stall), .stall_cause(stall_cause), .busy_vec(busy_vec),
      .pend_cnt(pend_cnt), .err(err), .stall_cycles(stall_cycles)
   );

   hazard_scoreboard #(.PERF_W(4)) dut_sat (
      .clk(clk), .rst_n(rst_n),
      .id_valid(s_vld), .id_rs1(s_rs1), .id_rs2(5'd0),
      .id_rs1_used(s_u1), .id_rs2_used(1'b0),
      .id_rd(s_rd), .id_reg_write(s_rw), .id_long(s_lng),
      .id_branch(1'b0), .ex_valid(1'b0), .ex_reg_write(1'b0),
      .ex_rd(5'd0), .wb_valid(1'b0), .wb_rd(5'd0), .flush(1'b0),
      .stall(s_stall), .stall_cause(s_cause), .busy_vec(s_busy),
      .pend_cnt(s_pend), .err(s_err), .stall_cycles(s_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(
      input logic vld, input logic [4:0] rs1, input logic u1,
      input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
      input logic rw, input logic lng, input logic br, input logic exv,
      input logic exw, input logic [4:0] exrd, input logic wbv,
      input logic [4:0] wbrd, input logic fl, input logic est,
      input logic [2:0] ecause);
      vec_t v;
      v.vld = vld; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
      v.rd = rd; v.rw = rw; v.lng = lng; v.br = br; v.exv = exv;
      v.exw = exw; v.exrd = exrd; v.wbv = wbv; v.wbrd = wbrd; v.fl = fl;
      v.est = est; v.ecause = ecause;
      return v;
   endfunction

   task automatic drv(input vec_t v);
      id_valid = v.vld; id_rs1 = v.rs1; id_rs1_used = v.u1;
      id_rs2 = v.rs2; id_rs2_used = v.u2; id_rd = v.rd;
      id_reg_write = v.rw; id_long = v.lng; id_branch = v.br;
      ex_valid = v.exv; ex_reg_write = v.exw; ex_rd = v.exrd;
      wb_valid = v.wbv; wb_rd = v.wbrd; flush = v.fl;
   endtask

   task automatic idle();
      drv(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
   endtask

   // Long-latency write issue of rd, optionally with a writeback of wbrd.
   function automatic vec_t lw(input logic [4:0] rd, input logic wbv, input logic [4:0] wbrd);
      return mk(1,0,0,0,0,rd,1,1,0,0,0,0,wbv,wbrd,0,0,0);
   endfunction

   function automatic vec_t wb(input logic [4:0] wbrd, input logic fl);
      return mk(0,0,0,0,0,0,0,0,0,0,0,0,1,wbrd,fl,0,0);
   endfunction

   function automatic vec_t use1(input logic [4:0] rs1, input logic wbv, input logic [4:0] wbrd);
      return mk(1,rs1,1,0,0,0,0,0,0,0,0,0,wbv,wbrd,0,0,0);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   initial begin
      // Busy registers {5,10}, pend_cnt 2 while the table is applied.
      tbl[0]  = mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0);
      tbl[1]  = mk(1,5,1,0,0,0,0,0,0,0,0,0,0,0,0, 1,1);
      tbl[2]  = mk(1,5,0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0);
      tbl[3]  = mk(1,0,0,10,1,0,0,0,0,0,0,0,0,0,0, 1,1);
      tbl[4]  = mk(1,5,1,0,0,0,0,0,0,0,0,0,1,5,0, 0,0);
      tbl[5]  = mk(1,0,1,0,1,0,0,0,1,1,1,0,0,0,0, 0,0);
      tbl[6]  = mk(1,0,0,7,1,0,0,0,1,1,1,7,0,0,0, 1,2);
      tbl[7]  = mk(1,0,0,7,1,0,0,0,0,1,1,7,0,0,0, 0,0);
      tbl[8]  = mk(1,7,1,0,0,0,0,0,1,1,0,7,0,0,0, 0,0);
      tbl[9]  = mk(1,0,0,0,0,10,1,1,0,0,0,0,0,0,0, 1,3);
      tbl[10] = mk(1,0,0,0,0,10,1,1,0,0,0,0,1,10,0, 0,0);
      tbl[11] = mk(1,0,0,0,0,5,1,0,0,0,0,0,0,0,0, 0,0);
      tbl[12] = mk(1,5,1,7,1,0,0,0,1,1,1,7,0,0,0, 1,1);
      tbl[13] = mk(1,5,1,0,0,0,0,0,0,0,0,0,0,0,1, 0,0);
      tbl[14] = mk(0,5,1,0,0,0,0,0,0,0,0,0,0,0,0, 0,0);
      tbl[15] = mk(1,7,1,0,0,10,1,1,1,1,1,7,0,0,0, 1,2);
      tbl[16] = mk(1,5,1,0,0,0,0,0,0,0,0,0,1,10,0, 1,1);

      s_vld = 0; s_u1 = 0; s_rw = 0; s_lng = 0; s_rs1 = 0; s_rd = 0;
      idle();
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      chk("reset busy_vec", busy_vec, 0);
      chk("reset pend_cnt", pend_cnt, 0);
      chk("reset err", err, 0);
      chk("reset stall_cycles", stall_cycles, 0);
      drv(tbl[6]);
      #1;
      chk("reset comb stall", stall, 1);
      chk("reset comb cause", stall_cause, 2);
      idle();
      tick();
      rst_n = 1'b1;
      tick();

      // Load-use: issue rd=5, dependent read stalls until its writeback.
      drv(lw(5, 0, 0));
      #1 chk("lu issue stall", stall, 0);
      tick();
      drv(use1(5, 0, 0));
      #1 chk("lu stall", stall, 1);
      chk("lu cause", stall_cause, 1);
      chk("lu pend", pend_cnt, 1);
      tick();
      chk("lu stall held", stall, 1);
      tick();
      drv(use1(5, 1, 5));
      #1 chk("lu wb stall", stall, 0);
      chk("lu wb cause", stall_cause, 0);
      tick();
      idle();
      #1 chk("lu busy cleared", busy_vec, 0);
      chk("lu pend cleared", pend_cnt, 0);
      chk("lu stall_cycles", stall_cycles, 2);

      drv(lw(5, 0, 0)); tick();
      drv(lw(10, 0, 0)); tick();
      idle();
      #1 chk("setup busy", busy_vec, 32'h0000_0420);
      chk("setup pend", pend_cnt, 2);

      for (int i = 0; i < 17; i++) begin
         drv(tbl[i]);
         #1;
         chk($sformatf("vec%0d stall", i), stall, tbl[i].est);
         chk($sformatf("vec%0d cause", i), stall_cause, tbl[i].ecause);
         idle();
         tick();
      end
      #1 chk("table busy kept", busy_vec, 32'h0000_0420);
      chk("table pend kept", pend_cnt, 2);
      chk("table stall_cycles", stall_cycles, 2);
      chk("table err", err, 0);

      // Same-cycle set and clear of register 9.
      drv(lw(9, 0, 0)); tick();
      drv(lw(9, 1, 9));
      #1 chk("setclr stall", stall, 0);
      tick();
      idle();
      #1 chk("setclr busy", busy_vec, 32'h0000_0620);
      chk("setclr pend", pend_cnt, 3);

      // Full: fourth outstanding write, then a fifth must wait.
      drv(lw(1, 0, 0)); tick();
      drv(lw(6, 0, 0));
      #1 chk("full pend", pend_cnt, 4);
      chk("full stall", stall, 1);
      chk("full cause", stall_cause, 4);
      tick();
      drv(lw(6, 1, 1));
      #1 chk("full wb stall", stall, 1);
      chk("full wb cause", stall_cause, 4);
      tick();
      idle();
      #1 chk("full after wb pend", pend_cnt, 3);
      drv(lw(6, 0, 0));
      #1 chk("full relieved stall", stall, 0);
      tick();
      idle();
      #1 chk("full reissue pend", pend_cnt, 4);
      chk("full reissue busy", busy_vec, 32'h0000_0660);
      chk("full stall_cycles", stall_cycles, 4);

      // Flush squashes RAW/FULL and issues nothing.
      drv(mk(1,5,1,0,0,12,1,1,0,0,0,0,0,0,1, 0,0));
      #1 chk("flush stall", stall, 0);
      chk("flush cause", stall_cause, 0);
      tick();
      idle();
      #1 chk("flush busy", busy_vec, 32'h0000_0660);
      chk("flush pend", pend_cnt, 4);

      drv(wb(3, 0)); tick(); idle();
      #1 chk("err set", err, 1);
      chk("err busy unchanged", busy_vec, 32'h0000_0660);
      chk("err pend unchanged", pend_cnt, 4);
      drv(wb(5, 1)); tick(); idle();
      #1 chk("flush wb busy", busy_vec, 32'h0000_0640);
      chk("flush wb pend", pend_cnt, 3);
      chk("err sticky", err, 1);

      // Reset mid-cycle with three writes outstanding.
      #2 rst_n = 1'b0;
      #1 chk("midrst busy", busy_vec, 0);
      chk("midrst pend", pend_cnt, 0);
      chk("midrst err", err, 0);
      chk("midrst stall_cycles", stall_cycles, 0);
      #1 rst_n = 1'b1;
      tick();
      drv(wb(9, 0)); tick(); idle();
      #1 chk("forgotten wb err", err, 1);
      chk("forgotten wb pend", pend_cnt, 0);

      // Saturation of a 4-bit stall counter.
      s_vld = 1; s_rw = 1; s_lng = 1; s_rd = 5;
      tick();
      s_rw = 0; s_lng = 0; s_rs1 = 5; s_u1 = 1;
      #1 chk("sat stall", s_stall, 1);
      chk("sat cause", s_cause, 1);
      chk("sat busy", s_busy, 32'h0000_0020);
      repeat (14) tick();
      chk("sat count 14", s_cycles, 14);
      repeat (3) tick();
      chk("sat count max", s_cycles, 15);
      chk("sat pend", s_pend, 1);
      chk("sat err", s_err, 0);
      s_vld = 0; s_u1 = 0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter REG_AW, default 5: register-address width; register file size NREG = 2**REG_AW.
REQ-002 SHALL have parameter MAX_PEND, default 4: maximum outstanding long-latency writes (range 1..NREG-1).
REQ-003 SHALL have parameter PERF_W, default 32: stall-cycle counter width.
REQ-004 SHALL use one clock; reset is asynchronous and active-low; ports: clk  input  1  rising-edge clock; rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have: id_valid  input  1  valid instruction in ID.
REQ-006 SHALL have: id_rs1, id_rs2  input  REG_AW  ID source registers; id_rs1_used, id_rs2_used  input  1  source actually read.
REQ-007 SHALL have: id_rd  input  REG_AW  ID destination; id_reg_write  input  1  ID writes rd; id_long  input  1  ID producer is long-latency (load, mul/div).
REQ-008 SHALL have: id_branch  input  1  ID instruction resolves branch/jalr in ID (operands needed final in ID).
REQ-009 SHALL have: ex_valid, ex_reg_write  input  1 each; ex_rd  input  REG_AW  EX-stage short-latency producer.
REQ-010 SHALL have: wb_valid  input  1  long-latency result completes; wb_rd  input  REG_AW  its destination.
REQ-011 SHALL have: flush  input  1  squash ID instruction this cycle.
REQ-012 SHALL have outputs: stall  1; stall_cause  3; busy_vec  NREG; pend_cnt  $clog2(MAX_PEND+1); err  1 sticky; stall_cycles  PERF_W.

Function
REQ-013 SHALL define match(rs) = id_valid & rs_used & rs!=0; register 0 never busy, never stalls.
REQ-014 SHALL raise RAW when match(rs) & busy_vec[rs] & !(wb_valid & wb_rd==rs) (WB result forwarded same cycle, no stall).
REQ-015 SHALL raise BR when id_branch & match(rs) & ex_valid & ex_reg_write & ex_rd==rs & ex_rd!=0.
REQ-016 SHALL raise WAW when id_valid & id_reg_write & id_long & id_rd!=0 & busy_vec[id_rd] & !(wb_valid & wb_rd==id_rd).
REQ-017 SHALL raise FULL when id_valid & id_reg_write & id_long & id_rd!=0 & pend_cnt==MAX_PEND (completion same cycle does not relieve).
REQ-018 SHALL drive stall = (RAW|BR|WAW|FULL) & !flush, combinationally, same cycle as inputs.
REQ-019 SHALL drive stall_cause by priority RAW=1, BR=2, WAW=3, FULL=4; 0 when stall=0.
REQ-020 SHALL define issue = id_valid & !stall & !flush & id_reg_write & id_long & id_rd!=0.
REQ-021 SHALL on issue set busy_vec[id_rd] at next clock edge.
REQ-022 SHALL on clear = wb_valid & wb_rd!=0 & busy_vec[wb_rd] clear busy_vec[wb_rd] at next edge.
REQ-023 SHALL, if set and clear target same register same cycle, leave it busy (set wins).
REQ-024 SHALL update pend_cnt = pend_cnt + issue - clear; never exceeds MAX_PEND, never wraps below 0.
REQ-025 SHALL set err (sticky until reset) on wb_valid & wb_rd!=0 & !busy_vec[wb_rd]; such writeback changes no state.
REQ-026 SHALL increment stall_cycles each cycle stall=1, saturating at all-ones.
REQ-027 SHALL ignore flush for busy/completion tracking: in-flight writebacks still clear bits.

Reset
REQ-028 SHALL on rst_n=0 asynchronously clear busy_vec, pend_cnt, err, stall_cycles to 0; stall/stall_cause follow REQ-018/019 from inputs.
REQ-029 SHALL resume tracking on the first rising clk edge after rst_n deasserts; ops in flight before reset are forgotten (their writebacks then set err).

Verification
REQ-030 Load-use: issue id_long rd=5; next cycle id_rs1=5 used -> stall=1, cause=1 until wb_valid wb_rd=5 cycle, where stall=0 and busy_vec[5]=0 next edge.
REQ-031 Branch-in-ID: ex_valid ex_reg_write ex_rd=7, id_branch id_rs2=7 used -> stall=1 cause=2; same with id_branch=0 -> stall=0.
REQ-032 Full: MAX_PEND=4, issue rd=1..4 -> pend_cnt=4; long op rd=6 -> stall=1 cause=4; wb_rd=2 -> pend_cnt=3 next cycle, rd=6 issues, pend_cnt=4.
REQ-033 Same-cycle set/clear: busy[9]=1, id_long rd=9 with wb_rd=9 -> stall=0, busy[9] stays 1, pend_cnt unchanged.
REQ-034 Flush/err/rs0: flush=1 during RAW -> stall=0, no busy set; wb_rd=3 not busy -> err=1; id_rs1=0 with busy stimuli -> stall=0.
REQ-035 Reset mid-operation: pend_cnt=3, rst_n low mid-cycle -> all state 0 immediately; stall_cycles saturates when preloaded near max with PERF_W=4.
